hazard_ctrl: RTL and testbench



---
 rtl/mips_pkg.sv | 14 +
 rtl/scoreboard.sv | 36 +++
 rtl/hazard_ctrl.sv | 107 ++++++++++
 tb/tb_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline sequencing logic.
package mips_pkg;

    localparam int NREG = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HOLD    = 2'd1,
        MEMWAIT = 2'd2,
        FLUSH   = 2'd3
    } state_t;

endpackage

// File: rtl/scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// retire, with a write-through view that hides registers retiring this cycle.
module scoreboard
    import mips_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clr_en,
    input  logic [4:0]      clr_idx,
    input  logic            set_en,
    input  logic [4:0]      set_idx,
    output logic [NREG-1:0] pending,
    output logic [NREG-1:0] pend_eff
);

    logic [NREG-1:0] clr;
    logic [NREG-1:0] set;

    assign clr = clr_en ? (NREG'(1) << clr_idx) : '0;

    // r0 is hardwired, so it never gets an in-flight writer
    assign set = (set_en && set_idx != REG_ZERO) ? (NREG'(1) << set_idx) : '0;

    assign pend_eff = pending & ~clr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr) | set;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-side sequencing: RAW/WAW interlock via the scoreboard, memory
// freeze, branch flush (deferred across memory waits) and a stall counter.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int NREG = 32,
    parameter int CNTW = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            d_valid,
    input  logic [4:0]      d_rs,
    input  logic [4:0]      d_rt,
    input  logic            d_use_rs,
    input  logic            d_use_rt,
    input  logic            d_rwe,
    input  logic [4:0]      d_dst,
    input  logic            x_taken,
    input  logic            w_rwe,
    input  logic [4:0]      w_dst,
    input  logic            dm_busy,
    output logic            issue,
    output logic            stall_f,
    output logic            stall_d,
    output logic            freeze,
    output logic            flush_d,
    output logic [NREG-1:0] pending,
    output logic [CNTW-1:0] stall_cnt
);

    state_t          state;
    state_t          state_next;
    logic            flush_pend;
    logic            hazard;
    logic            fl;
    logic [NREG-1:0] pend_eff;

    scoreboard #(
        .NREG(NREG)
    ) u_sb (
        .clock   (clock),
        .reset   (reset),
        .clr_en  (w_rwe),
        .clr_idx (w_dst),
        .set_en  (issue & d_rwe),
        .set_idx (d_dst),
        .pending (pending),
        .pend_eff(pend_eff)
    );

    assign hazard = d_valid & ((d_use_rs & pend_eff[d_rs])
                             | (d_use_rt & pend_eff[d_rt])
                             | (d_rwe    & pend_eff[d_dst]));

    assign fl      = (x_taken | flush_pend) & ~dm_busy;
    assign issue   = d_valid & ~hazard & ~dm_busy & ~fl;
    assign freeze  = dm_busy;
    assign flush_d = fl;
    assign stall_d = hazard & ~fl & ~dm_busy;
    assign stall_f = stall_d;

    always_comb begin
        state_next = RUN;
        if (dm_busy) begin
            state_next = MEMWAIT;
        end else if (fl) begin
            state_next = FLUSH;
        end else if (hazard) begin
            state_next = HOLD;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // A branch seen during a memory wait is replayed on the first free cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flush_pend <= 1'b0;
        end else if (fl) begin
            flush_pend <= 1'b0;
        end else if (x_taken && dm_busy) begin
            flush_pend <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall_d && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Entering FLUSH always consumes the deferred branch
    always_comb begin
        if (!reset && state == FLUSH) begin
            assert (!flush_pend);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table, corner sequences and randomized checking for hazard_ctrl.
module tb_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        d_valid = 0;
    logic [4:0]  d_rs = 0;
    logic [4:0]  d_rt = 0;
    logic        d_use_rs = 0;
    logic        d_use_rt = 0;
    logic        d_rwe = 0;
    logic [4:0]  d_dst = 0;
    logic        x_taken = 0;
    logic        w_rwe = 0;
    logic [4:0]  w_dst = 0;
    logic        dm_busy = 0;
    logic        issue;
    logic        stall_f;
    logic        stall_d;
    logic        freeze;
    logic        flush_d;
    logic [31:0] pending;
    logic [15:0] stall_cnt;

    int n_vec = 0;
    int n_bad = 0;

    hazard_ctrl #(
        .NREG(32),
        .CNTW(16)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .d_valid  (d_valid),
        .d_rs     (d_rs),
        .d_rt     (d_rt),
        .d_use_rs (d_use_rs),
        .d_use_rt (d_use_rt),
        .d_rwe    (d_rwe),
        .d_dst    (d_dst),
        .x_taken  (x_taken),
        .w_rwe    (w_rwe),
        .w_dst    (w_dst),
        .dm_busy  (dm_busy),
        .issue    (issue),
        .stall_f  (stall_f),
        .stall_d  (stall_d),
        .freeze   (freeze),
        .flush_d  (flush_d),
        .pending  (pending),
        .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        dv;
        logic [4:0]  rs;
        logic        urs;
        logic [4:0]  rt;
        logic        urt;
        logic        rwe;
        logic [4:0]  dst;
        logic        xt;
        logic        wrwe;
        logic [4:0]  wdst;
        logic        busy;
        logic        e_issue;
        logic        e_stall;
        logic        e_flush;
        logic        e_freeze;
        logic [31:0] e_pend;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic dv, input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt, input logic rwe,
                         input logic [4:0] dst, input logic xt, input logic wrwe,
                         input logic [4:0] wdst, input logic busy);
        d_valid = dv;  d_rs = rs;   d_use_rs = urs;
        d_rt = rt;     d_use_rt = urt;
        d_rwe = rwe;   d_dst = dst; x_taken = xt;
        w_rwe = wrwe;  w_dst = wdst; dm_busy = busy;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    // Reference model state
    bit m_pend[32];
    bit m_fp;
    int m_cnt;

    function automatic logic [31:0] m_pack();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
        m_fp = 0;
        m_cnt = 0;
    endtask

    initial begin
        // dv rs urs rt urt rwe dst xt wrwe wdst busy | issue stall flush freeze pend
        tbl[0]  = '{1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0,  1, 0, 0, 0, 32'h0};
        tbl[1]  = '{1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 32'h20};
        tbl[2]  = '{1, 0, 0, 0, 0, 1, 8, 0, 0, 0, 0,  1, 0, 0, 0, 32'h20};
        tbl[3]  = '{1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 32'h120};
        tbl[4]  = '{1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 32'h120};
        tbl[5]  = '{1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 32'h120};
        tbl[6]  = '{1, 8, 1, 0, 0, 0, 0, 0, 1, 8, 0,  1, 0, 0, 0, 32'h120};
        tbl[7]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 32'h20};
        tbl[8]  = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 32'h20};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0,  0, 0, 0, 0, 32'h20};
        tbl[10] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1,  0, 0, 0, 1, 32'h0};
        tbl[11] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 32'h0};
        tbl[12] = '{1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0,  0, 0, 1, 0, 32'h0};
        tbl[13] = '{1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0,  1, 0, 0, 0, 32'h0};
        tbl[14] = '{1, 0, 0, 0, 0, 1, 9, 0, 1, 9, 0,  1, 0, 0, 0, 32'h200};
        tbl[15] = '{1, 9, 1, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 32'h200};
        tbl[16] = '{1, 0, 0, 0, 0, 1, 10, 1, 0, 0, 0, 0, 0, 1, 0, 32'h200};
        tbl[17] = '{1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 32'h200};
        tbl[18] = '{1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0,  0, 1, 0, 0, 32'h200};

        // Reset state
        idle();
        #2;
        chk("rst_pending", pending, 32'h0);
        chk("rst_cnt", 32'(stall_cnt), 32'h0);
        chk("rst_issue", 32'(issue), 32'h0);
        next_cycle();
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].dv, tbl[i].rs, tbl[i].urs, tbl[i].rt, tbl[i].urt,
                  tbl[i].rwe, tbl[i].dst, tbl[i].xt, tbl[i].wrwe,
                  tbl[i].wdst, tbl[i].busy);
            #3;
            chk($sformatf("t%0d_issue", i), 32'(issue), 32'(tbl[i].e_issue));
            chk($sformatf("t%0d_stall_d", i), 32'(stall_d), 32'(tbl[i].e_stall));
            chk($sformatf("t%0d_stall_f", i), 32'(stall_f), 32'(tbl[i].e_stall));
            chk($sformatf("t%0d_flush", i), 32'(flush_d), 32'(tbl[i].e_flush));
            chk($sformatf("t%0d_freeze", i), 32'(freeze), 32'(tbl[i].e_freeze));
            chk($sformatf("t%0d_pending", i), pending, tbl[i].e_pend);
            if (i == 7) chk("raw_cnt", 32'(stall_cnt), 32'd3);
            next_cycle();
        end
        idle();
        #3;
        chk("tbl_end_pending", pending, 32'h200);
        chk("tbl_end_cnt", 32'(stall_cnt), 32'd5);

        // Fill r1..r15, hold on r1, then reset asynchronously mid-HOLD
        do_reset();
        for (int r = 1; r < 16; r++) begin
            drive(1, 0, 0, 0, 0, 1, 5'(r), 0, 0, 0, 0);
            next_cycle();
        end
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        chk("hold_stall", 32'(stall_d), 32'd1);
        chk("hold_pending", pending, 32'hFFFE);
        chk("hold_cnt", 32'(stall_cnt), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_pending", pending, 32'h0);
        chk("arst_cnt", 32'(stall_cnt), 32'h0);
        next_cycle();
        reset = 1'b0;
        #2;
        chk("post_rst_issue", 32'(issue), 32'd1);
        chk("post_rst_stall", 32'(stall_d), 32'd0);
        next_cycle();

        // Randomized run against the reference model
        do_reset();
        m_clear();
        for (int k = 0; k < 600; k++) begin
            bit dv, urs, urt, rwe, xt, wrwe, busy;
            bit haz, fl, iss, stl;
            bit pe[32];
            int rs, rt, dst, wdst;
            dv   = ($urandom_range(0, 9) < 8);
            urs  = $urandom_range(0, 1);
            urt  = $urandom_range(0, 1);
            rwe  = $urandom_range(0, 1);
            xt   = ($urandom_range(0, 9) < 1);
            wrwe = ($urandom_range(0, 9) < 4);
            busy = ($urandom_range(0, 9) < 2);
            rs   = $urandom_range(0, 7);
            rt   = $urandom_range(0, 7);
            dst  = $urandom_range(0, 7);
            wdst = $urandom_range(0, 7);
            drive(dv, 5'(rs), urs, 5'(rt), urt, rwe, 5'(dst), xt, wrwe,
                  5'(wdst), busy);

            for (int i = 0; i < 32; i++) pe[i] = m_pend[i] && !(wrwe && wdst == i);
            haz = dv && ((urs && pe[rs]) || (urt && pe[rt]) || (rwe && pe[dst]));
            fl  = (xt || m_fp) && !busy;
            iss = dv && !haz && !busy && !fl;
            stl = haz && !fl && !busy;

            #3;
            chk("rnd_issue", 32'(issue), 32'(iss));
            chk("rnd_stall_d", 32'(stall_d), 32'(stl));
            chk("rnd_stall_f", 32'(stall_f), 32'(stl));
            chk("rnd_flush", 32'(flush_d), 32'(fl));
            chk("rnd_freeze", 32'(freeze), 32'(busy));
            chk("rnd_pending", pending, m_pack());
            chk("rnd_cnt", 32'(stall_cnt), 32'(m_cnt));

            if (wrwe) m_pend[wdst] = 0;
            if (iss && rwe && dst != 0) m_pend[dst] = 1;
            if (fl) m_fp = 0;
            else if (xt && busy) m_fp = 1;
            if (stl && m_cnt < 65535) m_cnt++;
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
